// File: rtl/bp_cfg_boot_sequencer_if.sv
// Shared config-bus bundle between the boot sequencer (master) and the per-tile
// config endpoints (slave): one write channel plus a completion ack pulse.
interface bp_cfg_boot_sequencer_if #(
  parameter int core_id_width_p  = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
);
  logic                        cfg_v;
  logic                        cfg_ready;
  logic [core_id_width_p-1:0]  cfg_core;
  logic [cfg_addr_width_p-1:0] cfg_addr;
  logic [cfg_data_width_p-1:0] cfg_data;
  logic                        cfg_ack;

  modport master (
    output cfg_v, cfg_core, cfg_addr, cfg_data,
    input  cfg_ready, cfg_ack
  );

  modport slave (
    input  cfg_v, cfg_core, cfg_addr, cfg_data,
    output cfg_ready, cfg_ack
  );
endinterface

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config sequencer: freezes and programs every core tile over the shared
// config bus, unfreezes them all, and reports done once every write has been acked.
module bp_cfg_boot_sequencer #(
  parameter int num_core_p       = 2,
  parameter int core_id_width_p  = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int max_credits_p    = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  bp_cfg_boot_sequencer_if.master     cfg,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int CNT_W = $clog2(max_credits_p + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CONFIG   = 3'd1;
  localparam logic [2:0] UNFREEZE = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [cfg_addr_width_p-1:0] FREEZE_A    = cfg_addr_width_p'(8'h08);
  localparam logic [cfg_addr_width_p-1:0] CORE_ID_A   = cfg_addr_width_p'(8'h09);
  localparam logic [cfg_addr_width_p-1:0] ICACHE_ID_A = cfg_addr_width_p'(8'h0A);
  localparam logic [cfg_addr_width_p-1:0] DCACHE_ID_A = cfg_addr_width_p'(8'h0B);
  localparam logic [cfg_addr_width_p-1:0] CCE_ID_A    = cfg_addr_width_p'(8'h0C);
  localparam logic [cfg_addr_width_p-1:0] CCE_MODE_A  = cfg_addr_width_p'(8'h0D);

  localparam logic [2:0]                 LAST_REG  = 3'd5;
  localparam logic [core_id_width_p-1:0] LAST_CORE = core_id_width_p'(num_core_p - 1);
  localparam logic [CNT_W-1:0]           MAX_CRED  = CNT_W'(max_credits_p);

  function automatic logic [cfg_addr_width_p-1:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return FREEZE_A;
      3'd1:    return CORE_ID_A;
      3'd2:    return ICACHE_ID_A;
      3'd3:    return DCACHE_ID_A;
      3'd4:    return CCE_ID_A;
      default: return CCE_MODE_A;
    endcase
  endfunction

  function automatic logic [cfg_data_width_p-1:0] reg_data(
    input logic [2:0]                 idx,
    input logic [core_id_width_p-1:0] core,
    input logic                       mode
  );
    logic [cfg_data_width_p-1:0] ci;
    ci = cfg_data_width_p'(core);
    case (idx)
      3'd0:    return cfg_data_width_p'(1);
      3'd1:    return ci;
      3'd2:    return ci << 1;
      3'd3:    return (ci << 1) | cfg_data_width_p'(1);
      3'd4:    return ci;
      default: return cfg_data_width_p'(mode);
    endcase
  endfunction

  logic [2:0]                  state_q, state_d;
  logic [core_id_width_p-1:0]  ptr_core_q, ptr_core_d;
  logic [2:0]                  ptr_reg_q, ptr_reg_d;
  logic                        mode_q, mode_d;
  logic [CNT_W-1:0]            cred_q, cred_d;
  logic                        v_q, v_d;
  logic [core_id_width_p-1:0]  core_q, core_d;
  logic [cfg_addr_width_p-1:0] addr_q, addr_d;
  logic [cfg_data_width_p-1:0] data_q, data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic accept;
  logic slot_free;
  logic last_core;

  assign accept    = v_q & cfg.cfg_ready;
  assign last_core = (ptr_core_q == LAST_CORE);

  // Ack at zero outstanding is a stray and must not underflow the counter.
  always_comb begin
    cred_d = cred_q;
    if (accept && !cfg.cfg_ack)
      cred_d = cred_q + CNT_W'(1);
    else if (!accept && cfg.cfg_ack && cred_q != '0)
      cred_d = cred_q - CNT_W'(1);
  end

  // A new write may load when the output slot empties this cycle and the
  // post-update credit count still leaves room for it.
  assign slot_free = (!v_q || accept) && (cred_d < MAX_CRED);

  always_comb begin
    state_d    = state_q;
    ptr_core_d = ptr_core_q;
    ptr_reg_d  = ptr_reg_q;
    mode_d     = mode_q;
    v_d        = v_q & ~cfg.cfg_ready;
    core_d     = core_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = CONFIG;
          ptr_core_d = '0;
          ptr_reg_d  = '0;
          mode_d     = cce_mode_i;
        end
      end
      CONFIG: begin
        if (slot_free) begin
          v_d    = 1'b1;
          core_d = ptr_core_q;
          addr_d = reg_addr(ptr_reg_q);
          data_d = reg_data(ptr_reg_q, ptr_core_q, mode_q);
          if (ptr_reg_q == LAST_REG) begin
            ptr_reg_d = '0;
            if (last_core) begin
              ptr_core_d = '0;
              state_d    = UNFREEZE;
            end else begin
              ptr_core_d = ptr_core_q + 1'b1;
            end
          end else begin
            ptr_reg_d = ptr_reg_q + 3'd1;
          end
        end
      end
      UNFREEZE: begin
        if (slot_free) begin
          v_d    = 1'b1;
          core_d = ptr_core_q;
          addr_d = FREEZE_A;
          data_d = '0;
          if (last_core) begin
            ptr_core_d = '0;
            state_d    = DRAIN;
          end else begin
            ptr_core_d = ptr_core_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((!v_q || accept) && cred_d == '0)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == CONFIG) || (state_d == UNFREEZE) || (state_d == DRAIN);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      ptr_core_q <= '0;
      ptr_reg_q  <= '0;
      mode_q     <= 1'b0;
      cred_q     <= '0;
      v_q        <= 1'b0;
      core_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_core_q <= ptr_core_d;
      ptr_reg_q  <= ptr_reg_d;
      mode_q     <= mode_d;
      cred_q     <= cred_d;
      v_q        <= v_d;
      core_q     <= core_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cfg.cfg_v    = v_q;
  assign cfg.cfg_core = core_q;
  assign cfg.cfg_addr = addr_q;
  assign cfg.cfg_data = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Randomized bench for two sequencer configurations (N=2/4 credits, N=1/1 credit)
// checked against a write-list and credit reference model.
module tb_bp_cfg_boot_sequencer;

  logic clk;
  logic rst_n;
  logic [1:0] start, mode, rdy, ack;

  logic        v_w    [2];
  logic [3:0]  core_w [2];
  logic [15:0] addr_w [2];
  logic [63:0] data_w [2];
  logic        busy_w [2];
  logic        done_w [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int pct[2], dmin[2], dmax[2], hold_k[2], hold_n[2], stray[2];
  int k_m[2], out_m[2], st_m[2], first_acc[2], last_acc[2];
  logic mode_m[2];
  logic pv[2], pr[2];
  logic [3:0]  pcore[2];
  logic [15:0] paddr[2];
  logic [63:0] pdata[2];
  int dq[2][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int NC = (g == 0) ? 2 : 1;
    localparam int CR = (g == 0) ? 4 : 1;
    bp_cfg_boot_sequencer_if #(.core_id_width_p(4), .cfg_addr_width_p(16),
                               .cfg_data_width_p(64)) ifc ();
    bp_cfg_boot_sequencer #(
      .num_core_p(NC), .core_id_width_p(4), .cfg_addr_width_p(16),
      .cfg_data_width_p(64), .max_credits_p(CR)
    ) dut (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start[g]), .cce_mode_i(mode[g]),
      .cfg(ifc), .busy_o(busy_w[g]), .done_o(done_w[g])
    );
    assign ifc.cfg_ready = rdy[g];
    assign ifc.cfg_ack   = ack[g];
    assign v_w[g]    = ifc.cfg_v;
    assign core_w[g] = ifc.cfg_core;
    assign addr_w[g] = ifc.cfg_addr;
    assign data_w[g] = ifc.cfg_data;
  end

  function automatic int ncore(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic int ncred(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  // Expected write k of the 7N-write boot sequence.
  function automatic logic [15:0] exp_addr(input int k, input int n);
    return (k >= 6 * n) ? 16'h08 : 16'(8 + k % 6);
  endfunction

  function automatic logic [3:0] exp_core(input int k, input int n);
    return (k >= 6 * n) ? 4'(k - 6 * n) : 4'(k / 6);
  endfunction

  function automatic logic [63:0] exp_data(input int k, input int n, input logic m);
    int c;
    if (k >= 6 * n) return 64'd0;
    c = k / 6;
    case (k % 6)
      0:       return 64'd1;
      1:       return 64'(c);
      2:       return 64'(2 * c);
      3:       return 64'(2 * c + 1);
      4:       return 64'(c);
      default: return 64'(m);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int n, c, d;
    logic r, acc, a;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      n = ncore(g);
      c = ncred(g);
      if (!rst_n) begin
        k_m[g] = 0; out_m[g] = 0; st_m[g] = 0; pv[g] = 1'b0; pr[g] = 1'b0;
        dq[g].delete();
        rdy[g] = 1'b0; ack[g] = 1'b0;
      end else begin
        chk("busy", 64'(busy_w[g]), 64'(st_m[g] == 1));
        chk("done", 64'(done_w[g]), 64'(st_m[g] == 2));
        if (st_m[g] != 1) chk("v_idle", 64'(v_w[g]), 64'd0);
        if (pv[g] && !pr[g]) begin
          chk("hold_v", 64'(v_w[g]), 64'd1);
          chk("hold_core", 64'(core_w[g]), 64'(pcore[g]));
          chk("hold_addr", 64'(addr_w[g]), 64'(paddr[g]));
          chk("hold_data", data_w[g], pdata[g]);
        end
        r = ($urandom_range(99) < pct[g]);
        if (hold_n[g] > 0 && k_m[g] == hold_k[g] && v_w[g]) begin
          r = 1'b0;
          hold_n[g]--;
        end
        acc = v_w[g] && r;
        if (acc) begin
          chk("wr_count", 64'(k_m[g] < 7 * n), 64'd1);
          chk("wr_core", 64'(core_w[g]), 64'(exp_core(k_m[g], n)));
          chk("wr_addr", 64'(addr_w[g]), 64'(exp_addr(k_m[g], n)));
          chk("wr_data", data_w[g], exp_data(k_m[g], n, mode_m[g]));
          if (k_m[g] == 0) first_acc[g] = cyc;
          last_acc[g] = cyc;
          d = dmin[g] + $urandom_range(dmax[g] - dmin[g]);
          dq[g].push_back(cyc + d);
        end
        a = 1'b0;
        if (stray[g] > 0 && st_m[g] != 1) begin
          a = 1'b1;
          stray[g]--;
        end else begin
          for (int i = 0; i < dq[g].size(); i++)
            if (dq[g][i] <= cyc) begin
              dq[g].delete(i);
              a = 1'b1;
              break;
            end
        end
        if (v_w[g] && out_m[g] >= c) chk("credit", 64'(a), 64'd1);
        rdy[g] = r;
        ack[g] = a;
        pv[g] = v_w[g]; pr[g] = r;
        pcore[g] = core_w[g]; paddr[g] = addr_w[g]; pdata[g] = data_w[g];
        if (acc) k_m[g]++;
        if (acc && !a) out_m[g]++;
        else if (!acc && a && out_m[g] > 0) out_m[g]--;
        if (st_m[g] != 1 && start[g]) begin
          st_m[g] = 1; k_m[g] = 0; mode_m[g] = mode[g];
        end else if (st_m[g] == 1 && k_m[g] == 7 * n && out_m[g] == 0) begin
          st_m[g] = 2;
        end
      end
    end
  end

  task automatic pulse_start(input logic [1:0] mask);
    @(posedge clk); #2;
    start = mask;
    @(posedge clk); #2;
    start = 2'b00;
  endtask

  task automatic wait_all_done(input int bound);
    int t;
    t = 0;
    while (!(st_m[0] == 2 && st_m[1] == 2) && t < bound) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_timeout", 64'(t < bound), 64'd1);
    for (int g = 0; g < 2; g++) chk("total_writes", 64'(k_m[g]), 64'(7 * ncore(g)));
  endtask

  task automatic reset_outputs_check();
    for (int g = 0; g < 2; g++) begin
      chk("rst_v", 64'(v_w[g]), 64'd0);
      chk("rst_busy", 64'(busy_w[g]), 64'd0);
      chk("rst_done", 64'(done_w[g]), 64'd0);
      chk("rst_core", 64'(core_w[g]), 64'd0);
      chk("rst_addr", 64'(addr_w[g]), 64'd0);
      chk("rst_data", data_w[g], 64'd0);
    end
  endtask

  task automatic set_cfg(input int g, input int p, input int lo, input int hi, input logic m);
    pct[g] = p; dmin[g] = lo; dmax[g] = hi; mode[g] = m;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start = 2'b00; mode = 2'b00; rdy = 2'b00; ack = 2'b00;
    for (int g = 0; g < 2; g++) begin
      hold_k[g] = 0; hold_n[g] = 0; stray[g] = 0; first_acc[g] = 0; last_acc[g] = 0;
      set_cfg(g, 100, 0, 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #2;
    reset_outputs_check();
    rst_n = 1'b1;

    // In-order sequence with full ready; 1-credit instance with slow acks.
    set_cfg(0, 100, 3, 3, 1'b0);
    set_cfg(1, 100, 5, 5, 1'b1);
    pulse_start(2'b11);
    wait_all_done(2000);

    // Restart from DONE with cce_mode=1, random ready, a forced stall, and a
    // start pulse while busy; same-cycle acks on the single-core instance.
    set_cfg(0, 60, 0, 6, 1'b1);
    hold_k[0] = 3; hold_n[0] = 4;
    set_cfg(1, 100, 0, 0, 1'b1);
    pulse_start(2'b11);
    repeat (6) @(posedge clk);
    pulse_start(2'b01);
    wait_all_done(3000);
    chk("stall_consumed", 64'(hold_n[0]), 64'd0);
    chk("no_bubble", 64'(last_acc[1] - first_acc[1]), 64'd6);

    // Reset during UNFREEZE, stray acks, then a full rerun.
    set_cfg(0, 100, 4, 4, 1'b0);
    set_cfg(1, 80, 0, 3, 1'b0);
    pulse_start(2'b11);
    t = 0;
    while (k_m[0] < 12 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    chk("reach_unfreeze", 64'(t < 500), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    stray[0] = 3; stray[1] = 3;
    repeat (6) @(posedge clk);
    set_cfg(0, 70, 0, 5, 1'b1);
    set_cfg(1, 70, 0, 5, 1'b0);
    pulse_start(2'b11);
    wait_all_done(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
